// File: rtl/tube_sched_pkg.sv
// Shared types and constants for the tube display scheduler.
package tube_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  localparam int DEFAULT_DWELL_CYCLES = 50000000;

endpackage

// File: rtl/tube_display_scheduler_if.sv
// Requester, pin control and display-driver signals of the tube display scheduler.
interface tube_display_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [16*NUM_SRC-1:0] src_value;
  logic [NUM_SRC-1:0]    src_ack;
  logic                  pin_en;
  logic [SRC_W-1:0]      pin_sel;
  logic [SRC_W-1:0]      cur_src;
  logic [15:0]           tube_value;
  logic                  tube_set;

  modport master (
    output src_valid, src_value, pin_en, pin_sel,
    input  src_ack, cur_src, tube_value, tube_set
  );

  modport slave (
    input  src_valid, src_value, pin_en, pin_sel,
    output src_ack, cur_src, tube_value, tube_set
  );
endinterface

// File: rtl/tube_display_scheduler_rr_next_present.sv
// Combinational round-robin picker: first present index strictly after cur,
// wrapping, falling back to cur itself when it is the only present source.
module rr_next_present #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] present,
  input  logic [SRC_W-1:0]   cur,
  output logic [SRC_W-1:0]   next_idx,
  output logic               found
);
  logic [SRC_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    next_idx = cur;
    idx      = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = cur + SRC_W'(k);
      if (present[idx]) next_idx = idx;
    end
  end

  assign found = |present;
endmodule

// File: rtl/tube_display_scheduler.sv
// Multiplexes per-source 16-bit shadows onto one seven-segment display,
// rotating round-robin every DWELL_CYCLES or pinning a selected source.
module tube_display_scheduler
  import tube_sched_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SRC_W        = 2,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int CNT_W        = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  tube_display_scheduler_if.slave  bus
);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   cur_src_q, cur_src_d;
  logic [15:0]        tube_value_q, tube_value_d;
  logic               tube_set_q, tube_set_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [NUM_SRC-1:0] fresh_q, fresh_d;
  logic [NUM_SRC-1:0] present_q, present_d;
  logic [NUM_SRC-1:0] cap;
  logic [15:0]        shadow_q [NUM_SRC];
  logic [15:0]        shadow_d [NUM_SRC];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pin_en_q, pin_en_d;
  logic [SRC_W-1:0]   rr_next, low_idx;
  logic               rr_found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cap
      // The ack cycle blocks recapture, giving at most one capture per two cycles.
      assign cap[gi]      = bus.src_valid[gi] & ~ack_q[gi];
      assign shadow_d[gi] = cap[gi] ? bus.src_value[16*gi +: 16] : shadow_q[gi];
    end
  endgenerate

  rr_next_present #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_rr (
    .present  (present_q),
    .cur      (cur_src_q),
    .next_idx (rr_next),
    .found    (rr_found)
  );

  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (present_q[i]) low_idx = SRC_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_src_q    <= '0;
      tube_value_q <= '0;
      tube_set_q   <= 1'b0;
      ack_q        <= '0;
      fresh_q      <= '0;
      present_q    <= '0;
      cnt_q        <= '0;
      pin_en_q     <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      tube_value_q <= tube_value_d;
      tube_set_q   <= tube_set_d;
      ack_q        <= ack_d;
      fresh_q      <= fresh_d;
      present_q    <= present_d;
      cnt_q        <= cnt_d;
      pin_en_q     <= pin_en_d;
      for (int i = 0; i < NUM_SRC; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    case (state_q)
      S_IDLE: begin
        if (bus.pin_en) begin
          cur_src_d = bus.pin_sel;
          state_d   = S_LOAD;
        end else if (|present_q) begin
          cur_src_d = low_idx;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: state_d = S_DWELL;
      S_DWELL: begin
        if (bus.pin_en && (bus.pin_sel != cur_src_q || !pin_en_q)) begin
          cur_src_d = bus.pin_sel;
          state_d   = S_LOAD;
        end else if (fresh_q[cur_src_q]) begin
          state_d = S_LOAD;
        end else if (!bus.pin_en && cnt_q == DWELL_LAST) begin
          if (rr_found) begin
            cur_src_d = rr_next;
            state_d   = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tube_value_d = tube_value_q;
    tube_set_d   = 1'b0;
    cnt_d        = cnt_q;
    fresh_d      = fresh_q;
    pin_en_d     = bus.pin_en;
    if (state_q == S_LOAD) begin
      tube_value_d         = shadow_q[cur_src_q];
      tube_set_d           = 1'b1;
      cnt_d                = '0;
      fresh_d[cur_src_q]   = 1'b0;
    end else if (state_q == S_DWELL) begin
      // Held at zero while pinned so rotation resumes a full dwell after unpin.
      cnt_d = bus.pin_en ? '0 : cnt_q + CNT_W'(1);
    end
    fresh_d   = fresh_d | cap;
    present_d = present_q | cap;
    ack_d     = cap;
  end

  assign bus.src_ack    = ack_q;
  assign bus.cur_src    = cur_src_q;
  assign bus.tube_value = tube_value_q;
  assign bus.tube_set   = tube_set_q;
endmodule

// File: tb/tb_tube_display_scheduler.sv
// Directed bench for tube_display_scheduler with a short dwell of 8 cycles.
module tb_tube_display_scheduler;
  import tube_sched_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  tube_display_scheduler_if #(.NUM_SRC(4), .SRC_W(2)) bus ();

  tube_display_scheduler #(
    .NUM_SRC(4), .SRC_W(2), .DWELL_CYCLES(8), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tube_set is seen or max cycles pass; n is cycles stepped.
  task automatic wait_set(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tube_set && n < max);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.src_ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b, want 0000", bus.src_ack); end
    n_cmp++; if (bus.cur_src !== 2'd0) begin n_bad++; $display("FAIL reset_cur: got %0d, want 0", bus.cur_src); end
    n_cmp++; if (bus.tube_value !== 16'h0000) begin n_bad++; $display("FAIL reset_value: got %h, want 0000", bus.tube_value); end
    n_cmp++; if (bus.tube_set !== 1'b0) begin n_bad++; $display("FAIL reset_set: got %b, want 0", bus.tube_set); end
    $display("test_reset done");
  endtask

  task automatic test_first_capture();
    int n;
    rst = 1'b0;
    bus.src_valid = 4'b0100;
    bus.src_value = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
    step();
    n_cmp++; if (bus.src_ack !== 4'b0100) begin n_bad++; $display("FAIL first_ack: got %b, want 0100", bus.src_ack); end
    bus.src_valid = 4'b0000;
    step();
    n_cmp++; if (bus.src_ack !== 4'b0000) begin n_bad++; $display("FAIL first_ack_once: got %b, want 0000", bus.src_ack); end
    step();
    n_cmp++; if (bus.tube_set !== 1'b1) begin n_bad++; $display("FAIL first_set: got %b, want 1", bus.tube_set); end
    n_cmp++; if (bus.tube_value !== 16'h1234) begin n_bad++; $display("FAIL first_value: got %h, want 1234", bus.tube_value); end
    n_cmp++; if (bus.cur_src !== 2'd2) begin n_bad++; $display("FAIL first_cur: got %0d, want 2", bus.cur_src); end
    wait_set(20, n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL first_reload_gap: got %0d, want 9", n); end
    n_cmp++; if (bus.tube_value !== 16'h1234) begin n_bad++; $display("FAIL first_reload_value: got %h, want 1234", bus.tube_value); end
    $display("test_first_capture done");
  endtask

  task automatic test_rotation();
    int n;
    logic [15:0] ev [3];
    logic [1:0]  ec [3];
    ev[0] = 16'hBBBB; ev[1] = 16'hDDDD; ev[2] = 16'hAAAA;
    ec[0] = 2'd1;     ec[1] = 2'd3;     ec[2] = 2'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.src_valid = 4'b1011;
    bus.src_value = {16'hDDDD, 16'h0000, 16'hBBBB, 16'hAAAA};
    step();
    n_cmp++; if (bus.src_ack !== 4'b1011) begin n_bad++; $display("FAIL rot_ack: got %b, want 1011", bus.src_ack); end
    bus.src_valid = 4'b0000;
    wait_set(20, n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL rot_first_lat: got %0d, want 2", n); end
    n_cmp++; if (bus.tube_value !== 16'hAAAA) begin n_bad++; $display("FAIL rot_first_value: got %h, want aaaa", bus.tube_value); end
    n_cmp++; if (bus.cur_src !== 2'd0) begin n_bad++; $display("FAIL rot_first_cur: got %0d, want 0", bus.cur_src); end
    for (int i = 0; i < 3; i++) begin
      wait_set(20, n);
      n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL rot_gap%0d: got %0d, want 9", i, n); end
      n_cmp++; if (bus.tube_value !== ev[i]) begin n_bad++; $display("FAIL rot_value%0d: got %h, want %h", i, bus.tube_value, ev[i]); end
      n_cmp++; if (bus.cur_src !== ec[i]) begin n_bad++; $display("FAIL rot_cur%0d: got %0d, want %0d", i, bus.cur_src, ec[i]); end
    end
    $display("test_rotation done");
  endtask

  task automatic test_refresh();
    int n;
    wait_set(20, n);
    n_cmp++; if (bus.cur_src !== 2'd1) begin n_bad++; $display("FAIL refresh_pre_cur: got %0d, want 1", bus.cur_src); end
    step();
    step();
    bus.src_valid = 4'b0010;
    bus.src_value = {16'hDDDD, 16'h0000, 16'h0042, 16'hAAAA};
    step();
    bus.src_valid = 4'b0000;
    wait_set(20, n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL refresh_lat: got %0d, want 2", n); end
    n_cmp++; if (bus.tube_value !== 16'h0042) begin n_bad++; $display("FAIL refresh_value: got %h, want 0042", bus.tube_value); end
    n_cmp++; if (bus.cur_src !== 2'd1) begin n_bad++; $display("FAIL refresh_cur: got %0d, want 1", bus.cur_src); end
    wait_set(20, n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL refresh_next_gap: got %0d, want 9", n); end
    n_cmp++; if (bus.cur_src !== 2'd3) begin n_bad++; $display("FAIL refresh_next_cur: got %0d, want 3", bus.cur_src); end
    n_cmp++; if (bus.tube_value !== 16'hDDDD) begin n_bad++; $display("FAIL refresh_next_value: got %h, want dddd", bus.tube_value); end
    $display("test_refresh done");
  endtask

  task automatic test_pin();
    int n;
    int sets;
    wait_set(20, n);
    n_cmp++; if (bus.cur_src !== 2'd0) begin n_bad++; $display("FAIL pin_pre_cur: got %0d, want 0", bus.cur_src); end
    step();
    step();
    bus.pin_en  = 1'b1;
    bus.pin_sel = 2'd3;
    wait_set(20, n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL pin_lat: got %0d, want 2", n); end
    n_cmp++; if (bus.tube_value !== 16'hDDDD) begin n_bad++; $display("FAIL pin_value: got %h, want dddd", bus.tube_value); end
    n_cmp++; if (bus.cur_src !== 2'd3) begin n_bad++; $display("FAIL pin_cur: got %0d, want 3", bus.cur_src); end
    sets = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.tube_set) sets++;
    end
    n_cmp++; if (sets !== 0) begin n_bad++; $display("FAIL pin_hold_sets: got %0d, want 0", sets); end
    bus.pin_en = 1'b0;
    wait_set(20, n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL unpin_gap: got %0d, want 9", n); end
    n_cmp++; if (bus.cur_src !== 2'd0) begin n_bad++; $display("FAIL unpin_cur: got %0d, want 0", bus.cur_src); end
    n_cmp++; if (bus.tube_value !== 16'hAAAA) begin n_bad++; $display("FAIL unpin_value: got %h, want aaaa", bus.tube_value); end
    $display("test_pin done");
  endtask

  task automatic test_load_collision();
    for (int i = 0; i < 8; i++) step();
    bus.src_valid = 4'b0010;
    bus.src_value = {16'hDDDD, 16'h0000, 16'h5555, 16'hAAAA};
    step();
    bus.src_valid = 4'b0000;
    n_cmp++; if (bus.tube_set !== 1'b1) begin n_bad++; $display("FAIL coll_set1: got %b, want 1", bus.tube_set); end
    n_cmp++; if (bus.tube_value !== 16'h0042) begin n_bad++; $display("FAIL coll_old_value: got %h, want 0042", bus.tube_value); end
    n_cmp++; if (bus.cur_src !== 2'd1) begin n_bad++; $display("FAIL coll_cur: got %0d, want 1", bus.cur_src); end
    step();
    n_cmp++; if (bus.tube_set !== 1'b0) begin n_bad++; $display("FAIL coll_gap: got %b, want 0", bus.tube_set); end
    step();
    n_cmp++; if (bus.tube_set !== 1'b1) begin n_bad++; $display("FAIL coll_set2: got %b, want 1", bus.tube_set); end
    n_cmp++; if (bus.tube_value !== 16'h5555) begin n_bad++; $display("FAIL coll_new_value: got %h, want 5555", bus.tube_value); end
    $display("test_load_collision done");
  endtask

  task automatic test_reset_mid();
    int n;
    step();
    step();
    step();
    bus.src_valid = 4'b0001;
    bus.src_value = {16'h0000, 16'h0000, 16'h0000, 16'h7777};
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (bus.src_ack !== 4'b0000) begin n_bad++; $display("FAIL rmid_ack: got %b, want 0000", bus.src_ack); end
    n_cmp++; if (bus.tube_set !== 1'b0) begin n_bad++; $display("FAIL rmid_set: got %b, want 0", bus.tube_set); end
    n_cmp++; if (bus.tube_value !== 16'h0000) begin n_bad++; $display("FAIL rmid_value: got %h, want 0000", bus.tube_value); end
    n_cmp++; if (bus.cur_src !== 2'd0) begin n_bad++; $display("FAIL rmid_cur: got %0d, want 0", bus.cur_src); end
    n_cmp++; if (dut.state_q !== S_IDLE) begin n_bad++; $display("FAIL rmid_state: got %0d, want %0d", dut.state_q, S_IDLE); end
    rst = 1'b0;
    step();
    n_cmp++; if (bus.src_ack !== 4'b0001) begin n_bad++; $display("FAIL rmid_recap_ack: got %b, want 0001", bus.src_ack); end
    bus.src_valid = 4'b0000;
    wait_set(20, n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL rmid_lat: got %0d, want 2", n); end
    n_cmp++; if (bus.tube_value !== 16'h7777) begin n_bad++; $display("FAIL rmid_resume_value: got %h, want 7777", bus.tube_value); end
    n_cmp++; if (bus.cur_src !== 2'd0) begin n_bad++; $display("FAIL rmid_resume_cur: got %0d, want 0", bus.cur_src); end
    $display("test_reset_mid done");
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.src_valid = '0;
    bus.src_value = '0;
    bus.pin_en    = 1'b0;
    bus.pin_sel   = '0;
    test_reset();
    test_first_capture();
    test_rotation();
    test_refresh();
    test_pin();
    test_load_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
